// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM stage: access widths, FSM states, byte-lane patterns.
package mem_access_unit_pkg;

    // funct3[1:0] access width encodings
    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b10;
    localparam logic [1:0] MW_ILL  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mau_state_t;

    // Byte-enable patterns for the four-lane data bus
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_NONE    = 4'b0000;

    // Byte enables for an access of the given width at byte offset off
    function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] off);
        case (width)
            MW_BYTE: lane_be = BE_BYTE0 << off;
            MW_HALF: lane_be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            MW_WORD: lane_be = BE_WORD;
            default: lane_be = BE_NONE;
        endcase
    endfunction

    // An access faults when it crosses its natural alignment or the width is illegal
    function automatic logic lane_misaligned(input logic [1:0] width, input logic [1:0] off);
        lane_misaligned = ((width == MW_HALF) && off[0])
                        || ((width == MW_WORD) && (off != 2'b00))
                        || (width == MW_ILL);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed byte/half from a read word and extends it.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      width,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the lane at the access offset, then sign- or zero-extend it
    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            MW_BYTE: data = {{(XLEN-8){sign_ext & byte_sel[7]}}, byte_sel};
            MW_HALF: data = {{(XLEN-16){sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the req/ack data bus, aligns loads, registers MEM/WB.
//
// Handshake: upstream presents an instruction with valid_i and it is consumed on
// any rising edge where stall_o is low. On the bus, dmem_req_o and all request
// fields are held stable from the acceptance edge until the edge of a cycle in
// which dmem_ack_i is high; that edge completes the access (ack may coincide
// with the first request cycle).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            mem_write_i,
    input  logic            load_mem_i,
    input  logic [1:0]      mem_width_i,
    input  logic            mem_sign_extend_i,
    input  logic            reg_write_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misaligned_o,
    output mau_state_t      dbg_state_o
);

    mau_state_t      state_q, state_d;
    logic            is_mem, misal, accept, complete;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] load_data;

    // Request attributes captured at acceptance; live inputs are not trusted later
    logic [1:0]      lat_off, lat_width;
    logic            lat_sign, lat_load, lat_rw;
    logic [4:0]      lat_rd;

    assign off         = alu_result_i[1:0];
    assign is_mem      = valid_i & (load_mem_i | mem_write_i);
    assign misal       = lane_misaligned(mem_width_i, off);
    assign complete    = (state_q == BUSY) & dmem_ack_i;
    assign dbg_state_o = state_q;

    // Replicate store data across every lane the access may touch
    always_comb begin
        case (mem_width_i)
            MW_BYTE: wdata_d = {4{store_data_i[7:0]}};
            MW_HALF: wdata_d = {2{store_data_i[15:0]}};
            default: wdata_d = store_data_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state, stall and acceptance
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem && !misal) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = ~dmem_ack_i;
                if (dmem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request registers and latched request attributes
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            lat_off      <= '0;
            lat_width    <= '0;
            lat_sign     <= 1'b0;
            lat_load     <= 1'b0;
            lat_rw       <= 1'b0;
            lat_rd       <= '0;
        end else if (accept) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
            dmem_be_o    <= lane_be(mem_width_i, off);
            dmem_wdata_o <= wdata_d;
            lat_off      <= off;
            lat_width    <= mem_width_i;
            lat_sign     <= mem_sign_extend_i;
            lat_load     <= ~mem_write_i;
            lat_rw       <= reg_write_i;
            lat_rd       <= rd_i;
        end else if (complete) begin
            dmem_req_o   <= 1'b0;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (dmem_rdata_i),
        .offset   (lat_off),
        .width    (lat_width),
        .sign_ext (lat_sign),
        .data     (load_data)
    );

    // MEM/WB register: pass-through ops, faults and completed bus accesses
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            misaligned_o   <= 1'b0;
            if (state_q == IDLE) begin
                if (valid_i && !is_mem) begin
                    wb_valid_o     <= 1'b1;
                    wb_reg_write_o <= reg_write_i;
                    wb_rd_o        <= rd_i;
                    wb_data_o      <= alu_result_i;
                end else if (is_mem && misal) begin
                    wb_valid_o   <= 1'b1;
                    misaligned_o <= 1'b1;
                    wb_rd_o      <= rd_i;
                    wb_data_o    <= alu_result_i;
                end
            end else if (complete) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= lat_load & lat_rw;
                wb_rd_o        <= lat_rd;
                if (lat_load) wb_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expected values.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_write_i = 1'b0;
    logic        load_mem_i = 1'b0;
    logic [1:0]  mem_width_i = '0;
    logic        mem_sign_extend_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;
    mau_state_t  dbg_state_o;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.XLEN(32)) dut (
        .clk_i             (clk_i),
        .rst_n             (rst_n),
        .valid_i           (valid_i),
        .alu_result_i      (alu_result_i),
        .store_data_i      (store_data_i),
        .mem_write_i       (mem_write_i),
        .load_mem_i        (load_mem_i),
        .mem_width_i       (mem_width_i),
        .mem_sign_extend_i (mem_sign_extend_i),
        .reg_write_i       (reg_write_i),
        .rd_i              (rd_i),
        .stall_o           (stall_o),
        .dmem_req_o        (dmem_req_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_be_o         (dmem_be_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_ack_i        (dmem_ack_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .wb_valid_o        (wb_valid_o),
        .wb_reg_write_o    (wb_reg_write_o),
        .wb_rd_o           (wb_rd_o),
        .wb_data_o         (wb_data_o),
        .misaligned_o      (misaligned_o),
        .dbg_state_o       (dbg_state_o)
    );

    // Clock and run-time bound
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic drive_op(input logic st, input logic ld, input logic [1:0] w, input logic sx,
                            input logic rw, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] sd);
        valid_i           = 1'b1;
        mem_write_i       = st;
        load_mem_i        = ld;
        mem_width_i       = w;
        mem_sign_extend_i = sx;
        reg_write_i       = rw;
        rd_i              = rd;
        alu_result_i      = addr;
        store_data_i      = sd;
    endtask

    task automatic drive_idle();
        valid_i           = 1'b0;
        mem_write_i       = 1'b0;
        load_mem_i        = 1'b0;
        mem_width_i       = 2'b00;
        mem_sign_extend_i = 1'b0;
        reg_write_i       = 1'b0;
        rd_i              = '0;
        alu_result_i      = '0;
        store_data_i      = '0;
    endtask

    // One aligned access: accept, hold for 'waits' wait cycles, ack, check writeback
    task automatic mem_op(input string tag, input logic st, input logic [1:0] w, input logic sx,
                          input logic [31:0] addr, input logic [31:0] sd, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_rw);
        step();
        drive_op(st, ~st, w, sx, 1'b1, 5'd9, addr, sd);
        dmem_ack_i = 1'b0;
        #1 check({tag, "_stall_accept"}, stall_o, 1);
        step();
        check({tag, "_req"}, dmem_req_o, 1);
        check({tag, "_we"}, dmem_we_o, st);
        check({tag, "_addr"}, dmem_addr_o, exp_addr);
        check({tag, "_be"}, dmem_be_o, exp_be);
        if (st) check({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
        check({tag, "_wb_idle"}, wb_valid_o, 0);
        for (int i = 0; i < waits; i++) begin
            #1 check({tag, "_stall_wait"}, stall_o, 1);
            step();
            check({tag, "_req_held"}, dmem_req_o, 1);
            check({tag, "_addr_held"}, dmem_addr_o, exp_addr);
            check({tag, "_be_held"}, dmem_be_o, exp_be);
            check({tag, "_wb_wait"}, wb_valid_o, 0);
        end
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        #1 check({tag, "_stall_ack"}, stall_o, 0);
        step();
        dmem_ack_i = 1'b0;
        drive_idle();
        check({tag, "_req_drop"}, dmem_req_o, 0);
        check({tag, "_wb_valid"}, wb_valid_o, 1);
        check({tag, "_wb_rw"}, wb_reg_write_o, exp_rw);
        check({tag, "_misal"}, misaligned_o, 0);
        if (!st) begin
            check({tag, "_wb_data"}, wb_data_o, exp_data);
            check({tag, "_wb_rd"}, wb_rd_o, 9);
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req", dmem_req_o, 0);
        check("rst_we", dmem_we_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_misal", misaligned_o, 0);
        check("rst_state", dbg_state_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // Non-memory op passes through in one cycle
        drive_op(1'b0, 1'b0, MW_WORD, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
        #1 check("alu_stall", stall_o, 0);
        step();
        drive_idle();
        check("alu_wb_valid", wb_valid_o, 1);
        check("alu_wb_data", wb_data_o, 32'h1234);
        check("alu_wb_rd", wb_rd_o, 5);
        check("alu_wb_rw", wb_reg_write_o, 1);
        step();
        check("alu_wb_drop", wb_valid_o, 0);

        // Store byte at 0x103 with two wait cycles
        mem_op("sb", 1'b1, MW_BYTE, 1'b0, 32'h103, 32'hAABBCCDD, 2, 32'h0,
               32'h100, 4'b1000, 32'hDDDDDDDD, 32'h0, 1'b0);
        // Store half at 0x102 zero-wait
        mem_op("sh", 1'b1, MW_HALF, 1'b0, 32'h102, 32'h1234ABCD, 0, 32'h0,
               32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
        // Half loads, signed and unsigned
        mem_op("lh", 1'b0, MW_HALF, 1'b1, 32'h202, 32'h0, 0, 32'h80017FFF,
               32'h200, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1);
        mem_op("lhu", 1'b0, MW_HALF, 1'b0, 32'h202, 32'h0, 1, 32'h80017FFF,
               32'h200, 4'b1100, 32'h0, 32'h00008001, 1'b1);
        mem_op("lh_lo", 1'b0, MW_HALF, 1'b1, 32'h200, 32'h0, 0, 32'h80017FFF,
               32'h200, 4'b0011, 32'h0, 32'h00007FFF, 1'b1);
        // Byte and word loads
        mem_op("lbu", 1'b0, MW_BYTE, 1'b0, 32'h301, 32'h0, 0, 32'h11223344,
               32'h300, 4'b0010, 32'h0, 32'h00000033, 1'b1);
        mem_op("lb", 1'b0, MW_BYTE, 1'b1, 32'h303, 32'h0, 0, 32'h80223344,
               32'h300, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1);
        mem_op("lw", 1'b0, MW_WORD, 1'b1, 32'h300, 32'h0, 0, 32'h11223344,
               32'h300, 4'b1111, 32'h0, 32'h11223344, 1'b1);

        // Misaligned word load and illegal-width store
        step();
        drive_op(1'b0, 1'b1, MW_WORD, 1'b1, 1'b1, 5'd3, 32'h402, 32'h0);
        #1 check("mis_lw_stall", stall_o, 0);
        step();
        check("mis_lw_req", dmem_req_o, 0);
        check("mis_lw_valid", wb_valid_o, 1);
        check("mis_lw_flag", misaligned_o, 1);
        check("mis_lw_rw", wb_reg_write_o, 0);
        drive_op(1'b1, 1'b0, MW_ILL, 1'b0, 1'b0, 5'd0, 32'h400, 32'h55);
        #1 check("mis_ill_stall", stall_o, 0);
        step();
        drive_idle();
        check("mis_ill_req", dmem_req_o, 0);
        check("mis_ill_valid", wb_valid_o, 1);
        check("mis_ill_flag", misaligned_o, 1);
        check("mis_ill_rw", wb_reg_write_o, 0);
        step();
        check("mis_pulse_end", misaligned_o, 0);
        check("mis_valid_end", wb_valid_o, 0);

        // Reset while an access is outstanding
        drive_op(1'b0, 1'b1, MW_WORD, 1'b0, 1'b1, 5'd4, 32'h500, 32'h0);
        step();
        check("rb_req", dmem_req_o, 1);
        check("rb_state", dbg_state_o, 1);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("rb_req_drop", dmem_req_o, 0);
        check("rb_state_idle", dbg_state_o, 0);
        step();
        rst_n = 1'b1;
        mem_op("post_rst", 1'b0, MW_BYTE, 1'b0, 32'h301, 32'h0, 0, 32'h11223344,
               32'h300, 4'b0010, 32'h0, 32'h00000033, 1'b1);

        // Back-to-back loads: next op presented on the completing edge
        step();
        drive_op(1'b0, 1'b1, MW_WORD, 1'b0, 1'b1, 5'd10, 32'h600, 32'h0);
        step();
        check("b2b_a_req", dmem_req_o, 1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        step();
        check("b2b_a_valid", wb_valid_o, 1);
        check("b2b_a_data", wb_data_o, 32'hCAFEF00D);
        check("b2b_a_rd", wb_rd_o, 10);
        dmem_ack_i = 1'b0;
        drive_op(1'b0, 1'b1, MW_BYTE, 1'b1, 1'b1, 5'd11, 32'h602, 32'h0);
        #1 check("b2b_b_stall", stall_o, 1);
        step();
        check("b2b_b_req", dmem_req_o, 1);
        check("b2b_b_be", dmem_be_o, 4'b0100);
        check("b2b_bubble", wb_valid_o, 0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h00F10000;
        step();
        dmem_ack_i = 1'b0;
        drive_idle();
        check("b2b_b_valid", wb_valid_o, 1);
        check("b2b_b_data", wb_data_o, 32'hFFFFFFF1);
        check("b2b_b_rd", wb_rd_o, 11);
        step();
        check("b2b_end", wb_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
